// File: rtl/noc_pkg.sv
// Shared NoC router types: port indices and the flit payload carried on links.
package noc_pkg;

  localparam int unsigned PORT_NUM = 5;
  localparam int unsigned VC_W     = 2;
  localparam int unsigned DATA_W   = 32;

  // Port index i is the requester index i inside each output arbiter
  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t       flit_label;
    logic [VC_W-1:0]   vc_id;
    logic [DATA_W-1:0] data;
  } flit_t;

endpackage

// File: rtl/noc_output_port_arbiter.sv
// Per-output-port switch allocator: round-robin packet-granular arbitration
// among NUM_REQ inputs, wormhole locking HEAD..TAIL, credit-gated forwarding.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid_i       per-input flit valid
//   req_flit_i        per-input flit (packed array of flit_t)
//   req_ready_o       per-input accept, combinational from inputs and state
//   out_valid_o       registered output flit valid
//   out_flit_o        registered output flit (holds when not valid)
//   credit_return_i   one downstream buffer slot freed this cycle
//   grant_o           one-hot packet owner while locked, zero when idle
//   locked_o          packet in progress
//   credits_o         current credit count
//   err_o             sticky protocol / credit overflow error
module noc_output_port_arbiter #(
  parameter int unsigned NUM_REQ      = noc_pkg::PORT_NUM,
  parameter int unsigned BUFFER_DEPTH = 8,
  parameter int unsigned CREDIT_W     = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  noc_pkg::flit_t [NUM_REQ-1:0]        req_flit_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic                                out_valid_o,
  output noc_pkg::flit_t                      out_flit_o,
  input  logic                                credit_return_i,
  output logic [NUM_REQ-1:0]                  grant_o,
  output logic                                locked_o,
  output logic [CREDIT_W-1:0]                 credits_o,
  output logic                                err_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                r_state, w_state_n;
  logic [IDX_W-1:0]      r_owner, w_owner_n;
  logic [IDX_W-1:0]      r_rr_ptr, w_rr_n;
  logic [CREDIT_W-1:0]   r_credits, w_credits_n;
  logic                  r_out_valid;
  noc_pkg::flit_t        r_out_flit;
  logic [NUM_REQ-1:0]    r_grant;
  logic                  r_err;

  logic [NUM_REQ-1:0]    w_eligible;
  logic                  w_found;
  logic [IDX_W-1:0]      w_winner;
  int unsigned           w_idx;
  logic                  w_has_credit;
  logic                  w_xfer;
  noc_pkg::flit_t        w_xfer_flit;
  logic                  w_err_set;

  assign w_has_credit = (r_credits != '0);

  // Only packet-opening flits may compete for the link
  always_comb begin
    w_eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_eligible[i] = req_valid_i[i] &&
                      ((req_flit_i[i].flit_label == noc_pkg::HEAD) ||
                       (req_flit_i[i].flit_label == noc_pkg::HEADTAIL));
    end
  end

  // Round-robin search starting just after the last packet's owner
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = (32'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && w_eligible[IDX_W'(w_idx)]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'(w_idx);
      end
    end
  end

  // Next state, handshake, forwarding and credit bookkeeping
  always_comb begin
    w_state_n   = r_state;
    w_owner_n   = r_owner;
    w_rr_n      = r_rr_ptr;
    w_credits_n = r_credits;
    req_ready_o = '0;
    w_xfer      = 1'b0;
    w_xfer_flit = '0;
    w_err_set   = 1'b0;

    case (r_state)
      IDLE: begin
        // Without credit the winner is computed but nothing is committed
        if (w_found && w_has_credit) begin
          req_ready_o[w_winner] = 1'b1;
          w_xfer      = 1'b1;
          w_xfer_flit = req_flit_i[w_winner];
          if (w_xfer_flit.flit_label == noc_pkg::HEAD) begin
            w_state_n = LOCKED;
            w_owner_n = w_winner;
          end else begin
            w_rr_n = w_winner;
          end
        end
      end
      LOCKED: begin
        req_ready_o[r_owner] = w_has_credit;
        if (req_valid_i[r_owner] && w_has_credit) begin
          w_xfer      = 1'b1;
          w_xfer_flit = req_flit_i[r_owner];
          case (w_xfer_flit.flit_label)
            noc_pkg::TAIL: begin
              w_state_n = IDLE;
              w_rr_n    = r_owner;
            end
            noc_pkg::HEADTAIL: begin
              w_state_n = IDLE;
              w_rr_n    = r_owner;
              w_err_set = 1'b1;
            end
            // A second HEAD is flagged but the packet stays open
            noc_pkg::HEAD: w_err_set = 1'b1;
            default: ;
          endcase
        end
      end
      default: w_state_n = IDLE;
    endcase

    case ({w_xfer, credit_return_i})
      2'b10: w_credits_n = r_credits - CREDIT_W'(1);
      2'b01: begin
        if (r_credits == CREDIT_W'(BUFFER_DEPTH)) begin
          w_err_set = 1'b1;
        end else begin
          w_credits_n = r_credits + CREDIT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
      r_credits   <= CREDIT_W'(BUFFER_DEPTH);
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_grant     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_owner     <= w_owner_n;
      r_rr_ptr    <= w_rr_n;
      r_credits   <= w_credits_n;
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_flit <= w_xfer_flit;
      end
      r_grant     <= (w_state_n == LOCKED) ? (NUM_REQ'(1) << w_owner_n) : '0;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_flit_o  = r_out_flit;
  assign grant_o     = r_grant;
  assign locked_o    = (r_state == LOCKED);
  assign credits_o   = r_credits;
  assign err_o       = r_err;

endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// Self-checking bench for noc_output_port_arbiter: per-scenario tasks check
// handshakes and state inline; a scoreboard checks every output flit and its
// one-cycle latency.
module tb_noc_output_port_arbiter;
  import noc_pkg::*;

  localparam int unsigned N  = 5;
  localparam int unsigned CW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  flit_t [N-1:0]   req_flit = '0;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  flit_t           out_flit;
  logic            credit_return = 1'b0;
  logic [N-1:0]    grant;
  logic            locked;
  logic [CW-1:0]   credits;
  logic            err;

  typedef struct packed {
    flit_t flit;
    int    cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests_run = 0;
  int   fails = 0;

  noc_output_port_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid),
    .req_flit_i      (req_flit),
    .req_ready_o     (req_ready),
    .out_valid_o     (out_valid),
    .out_flit_o      (out_flit),
    .credit_return_i (credit_return),
    .grant_o         (grant),
    .locked_o        (locked),
    .credits_o       (credits),
    .err_o           (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic flit_t mk(input flit_label_t l, input logic [1:0] vc, input logic [31:0] d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = vc;
    f.data       = d;
    return f;
  endfunction

  // Scoreboard: each output flit must match the oldest expected one, one cycle later
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: got valid flit %h, want no output", out_flit);
      end else begin
        e = exp_q.pop_front();
        if (out_flit !== e.flit || cyc != e.cyc + 1) begin
          fails++;
          $display("FAIL out_flit: got %h at cycle %0d, want %h at cycle %0d",
                   out_flit, cyc, e.flit, e.cyc + 1);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc + 1 <= cyc) begin
      tests_run++;
      fails++;
      $display("FAIL out_missing: got no output at cycle %0d, want %h", cyc, exp_q[0].flit);
      void'(exp_q.pop_front());
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    req_valid = '0;
    credit_return = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    credit_return = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    do_reset(2);
    tests_run += 6;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (out_flit !== '0) begin fails++; $display("FAIL rst_out_flit: got %h want 0", out_flit); end
    if (grant !== '0) begin fails++; $display("FAIL rst_grant: got %b want 0", grant); end
    if (locked !== 1'b0) begin fails++; $display("FAIL rst_locked: got %b want 0", locked); end
    if (credits !== CW'(8)) begin fails++; $display("FAIL rst_credits: got %0d want 8", credits); end
    if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err); end
  endtask

  task automatic test_single_flit;
    do_reset(1);
    req_flit[2] = mk(HEADTAIL, 2'd3, 32'hA5A5_0002);
    req_valid = 5'b00100;
    #1;
    tests_run++;
    if (req_ready !== 5'b00100) begin fails++; $display("FAIL single_ready: got %b want 00100", req_ready); end
    exp_q.push_back('{flit: req_flit[2], cyc: cyc});
    @(posedge clk); #1;
    req_valid = '0;
    tests_run += 3;
    if (credits !== CW'(7)) begin fails++; $display("FAIL single_credits: got %0d want 7", credits); end
    if (locked !== 1'b0) begin fails++; $display("FAIL single_locked: got %b want 0", locked); end
    if (grant !== '0) begin fails++; $display("FAIL single_grant: got %b want 0", grant); end
    idle(1);
    @(negedge clk); #1;
    tests_run++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL single_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_fairness;
    int order [6] = '{0, 1, 4, 0, 1, 4};
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      req_flit[0] = mk(HEADTAIL, 2'd0, 32'(256 * 0 + k));
      req_flit[1] = mk(HEADTAIL, 2'd1, 32'(256 * 1 + k));
      req_flit[4] = mk(HEADTAIL, 2'd2, 32'(256 * 4 + k));
      req_valid = 5'b10011;
      credit_return = (k > 0);
      #1;
      tests_run++;
      if (req_ready !== (N'(1) << order[k])) begin
        fails++;
        $display("FAIL fair_ready[%0d]: got %b want port %0d", k, req_ready, order[k]);
      end
      exp_q.push_back('{flit: req_flit[order[k]], cyc: cyc});
      @(posedge clk); #1;
      tests_run += 2;
      if (credits !== CW'(7)) begin fails++; $display("FAIL fair_credits[%0d]: got %0d want 7", k, credits); end
      if (grant !== '0) begin fails++; $display("FAIL fair_grant[%0d]: got %b want 0", k, grant); end
    end
    idle(1);
    @(negedge clk); #1;
    tests_run += 2;
    if (exp_q.size() != 0) begin fails++; $display("FAIL fair_drain: got %0d pending want 0", exp_q.size()); end
    if (err !== 1'b0) begin fails++; $display("FAIL fair_err: got %b want 0", err); end
  endtask

  task automatic test_packet_lock;
    flit_label_t lbl [4] = '{HEAD, BODY, BODY, TAIL};
    do_reset(1);
    req_flit[0] = mk(HEAD, 2'd1, 32'h0000_0E00);
    for (int k = 0; k < 4; k++) begin
      req_flit[3] = mk(lbl[k], 2'd2, 32'h0000_3300 + 32'(k));
      req_valid = (k == 0) ? 5'b01000 : 5'b01001;
      #1;
      tests_run++;
      if (req_ready !== 5'b01000) begin fails++; $display("FAIL lock_ready[%0d]: got %b want 01000", k, req_ready); end
      exp_q.push_back('{flit: req_flit[3], cyc: cyc});
      @(posedge clk); #1;
      if (k < 3) begin
        tests_run += 2;
        if (locked !== 1'b1) begin fails++; $display("FAIL lock_locked[%0d]: got %b want 1", k, locked); end
        if (grant !== 5'b01000) begin fails++; $display("FAIL lock_grant[%0d]: got %b want 01000", k, grant); end
      end
    end
    tests_run += 2;
    if (locked !== 1'b0) begin fails++; $display("FAIL lock_after_tail: got %b want 0", locked); end
    if (grant !== '0) begin fails++; $display("FAIL lock_grant_idle: got %b want 0", grant); end
    req_valid = 5'b00001;
    #1;
    tests_run++;
    if (req_ready !== 5'b00001) begin fails++; $display("FAIL lock_next_ready: got %b want 00001", req_ready); end
    exp_q.push_back('{flit: req_flit[0], cyc: cyc});
    @(posedge clk); #1;
    tests_run++;
    if (grant !== 5'b00001) begin fails++; $display("FAIL lock_next_grant: got %b want 00001", grant); end
    req_flit[0] = mk(TAIL, 2'd1, 32'h0000_0E01);
    #1;
    exp_q.push_back('{flit: req_flit[0], cyc: cyc});
    @(posedge clk); #1;
    idle(1);
    @(negedge clk); #1;
    tests_run += 2;
    if (exp_q.size() != 0) begin fails++; $display("FAIL lock_drain: got %0d pending want 0", exp_q.size()); end
    if (credits !== CW'(2)) begin fails++; $display("FAIL lock_credits: got %0d want 2", credits); end
  endtask

  task automatic test_credit_exhaustion;
    flit_t pkt [10];
    for (int k = 0; k < 10; k++) begin
      pkt[k] = mk((k == 0) ? HEAD : ((k == 9) ? TAIL : BODY), 2'd1, 32'hC000_0000 + 32'(k));
    end
    do_reset(1);
    req_valid = 5'b00100;
    for (int k = 0; k < 8; k++) begin
      req_flit[2] = pkt[k];
      #1;
      tests_run++;
      if (req_ready !== 5'b00100) begin fails++; $display("FAIL exh_ready[%0d]: got %b want 00100", k, req_ready); end
      exp_q.push_back('{flit: pkt[k], cyc: cyc});
      @(posedge clk); #1;
    end
    req_flit[2] = pkt[8];
    #1;
    tests_run += 3;
    if (credits !== '0) begin fails++; $display("FAIL exh_credits: got %0d want 0", credits); end
    if (req_ready !== '0) begin fails++; $display("FAIL exh_ready_zero: got %b want 00000", req_ready); end
    if (locked !== 1'b1) begin fails++; $display("FAIL exh_locked: got %b want 1", locked); end
    @(posedge clk); #1;
    credit_return = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== '0) begin fails++; $display("FAIL exh_ready_on_return: got %b want 00000", req_ready); end
    @(posedge clk); #1;
    credit_return = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 5'b00100) begin fails++; $display("FAIL exh_ready_after_return: got %b want 00100", req_ready); end
    exp_q.push_back('{flit: pkt[8], cyc: cyc});
    @(posedge clk); #1;
    req_flit[2] = pkt[9];
    credit_return = 1'b1;
    #1;
    tests_run += 2;
    if (credits !== '0) begin fails++; $display("FAIL exh_credits2: got %0d want 0", credits); end
    if (req_ready !== '0) begin fails++; $display("FAIL exh_ready_tail: got %b want 00000", req_ready); end
    @(posedge clk); #1;
    credit_return = 1'b0;
    exp_q.push_back('{flit: pkt[9], cyc: cyc});
    @(posedge clk); #1;
    tests_run++;
    if (locked !== 1'b0) begin fails++; $display("FAIL exh_closed: got %b want 0", locked); end
    idle(1);
    @(negedge clk); #1;
    tests_run++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL exh_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_credit_boundary;
    do_reset(1);
    req_valid = 5'b00001;
    for (int k = 0; k < 4; k++) begin
      req_flit[0] = mk(HEADTAIL, 2'd0, 32'hB000_0000 + 32'(k));
      credit_return = (k == 3);
      #1;
      exp_q.push_back('{flit: req_flit[0], cyc: cyc});
      @(posedge clk); #1;
    end
    tests_run++;
    if (credits !== CW'(5)) begin fails++; $display("FAIL bnd_simul: got %0d want 5", credits); end
    req_valid = '0;
    credit_return = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    tests_run += 2;
    if (credits !== CW'(8)) begin fails++; $display("FAIL bnd_full: got %0d want 8", credits); end
    if (err !== 1'b0) begin fails++; $display("FAIL bnd_err_early: got %b want 0", err); end
    @(posedge clk); #1;
    credit_return = 1'b0;
    tests_run += 2;
    if (credits !== CW'(8)) begin fails++; $display("FAIL bnd_saturate: got %0d want 8", credits); end
    if (err !== 1'b1) begin fails++; $display("FAIL bnd_err: got %b want 1", err); end
    idle(2);
    @(negedge clk); #1;
    tests_run += 2;
    if (err !== 1'b1) begin fails++; $display("FAIL bnd_err_sticky: got %b want 1", err); end
    if (exp_q.size() != 0) begin fails++; $display("FAIL bnd_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_protocol_err;
    flit_label_t lbl [3] = '{HEAD, HEAD, TAIL};
    do_reset(1);
    req_valid = 5'b00010;
    for (int k = 0; k < 3; k++) begin
      req_flit[1] = mk(lbl[k], 2'd3, 32'hE000_0000 + 32'(k));
      #1;
      tests_run++;
      if (req_ready !== 5'b00010) begin fails++; $display("FAIL perr_ready[%0d]: got %b want 00010", k, req_ready); end
      exp_q.push_back('{flit: req_flit[1], cyc: cyc});
      @(posedge clk); #1;
      if (k == 1) begin
        tests_run += 2;
        if (err !== 1'b1) begin fails++; $display("FAIL perr_err: got %b want 1", err); end
        if (locked !== 1'b1) begin fails++; $display("FAIL perr_still_locked: got %b want 1", locked); end
      end
    end
    tests_run++;
    if (locked !== 1'b0) begin fails++; $display("FAIL perr_closed: got %b want 0", locked); end
    idle(1);
    @(negedge clk); #1;
    tests_run++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL perr_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_packet;
    do_reset(1);
    req_flit[4] = mk(HEAD, 2'd2, 32'hD000_0000);
    req_valid = 5'b10000;
    #1;
    tests_run++;
    if (req_ready !== 5'b10000) begin fails++; $display("FAIL mid_head_ready: got %b want 10000", req_ready); end
    exp_q.push_back('{flit: req_flit[4], cyc: cyc});
    @(posedge clk); #1;
    req_flit[4] = mk(BODY, 2'd2, 32'hD000_0001);
    #1;
    exp_q.push_back('{flit: req_flit[4], cyc: cyc});
    @(posedge clk); #1;
    do_reset(1);
    tests_run += 4;
    if (locked !== 1'b0) begin fails++; $display("FAIL mid_locked: got %b want 0", locked); end
    if (grant !== '0) begin fails++; $display("FAIL mid_grant: got %b want 0", grant); end
    if (credits !== CW'(8)) begin fails++; $display("FAIL mid_credits: got %0d want 8", credits); end
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    req_flit[1] = mk(HEADTAIL, 2'd1, 32'hD000_0101);
    req_valid = 5'b00010;
    #1;
    tests_run++;
    if (req_ready !== 5'b00010) begin fails++; $display("FAIL mid_new_ready: got %b want 00010", req_ready); end
    exp_q.push_back('{flit: req_flit[1], cyc: cyc});
    @(posedge clk); #1;
    idle(1);
    @(negedge clk); #1;
    tests_run++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL mid_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_flit();
    test_fairness();
    test_packet_lock();
    test_credit_exhaustion();
    test_credit_boundary();
    test_protocol_err();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/noc_output_port_arbiter.md
Name: noc_output_port_arbiter

Overview:
- Per-output-port switch allocator for the mesh router. Shares one output link among NUM_REQ input ports (LOCAL, NORTH, SOUTH, WEST, EAST).
- Uses round-robin arbitration at packet granularity. The grant is held from HEAD to TAIL so flits of different packets never interleave.
- Gates forwarding on a credit counter that mirrors free slots in the downstream input buffer. Drives one registered flit_t onto the link per cycle.

Parameters:
- NUM_REQ, 5 (noc_pkg::PORT_NUM): number of requesting input ports; index i corresponds to port_t value i.
- BUFFER_DEPTH, 8: downstream input buffer depth, which is also the initial credit count.
- CREDIT_W, $clog2(BUFFER_DEPTH+1): credit counter width (derived; do not override).

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-input flit valid
- req_flit_i  in  NUM_REQ x $bits(noc_pkg::flit_t)  per-input flit, packed array of flit_t
- req_ready_o  out  NUM_REQ  per-input accept; transfer when valid & ready
- out_valid_o  out  1  output flit valid
- out_flit_o  out  $bits(noc_pkg::flit_t)  output flit, registered
- credit_return_i  in  1  one downstream slot freed this cycle
- grant_o  out  NUM_REQ  one-hot current packet owner; zero when idle
- locked_o  out  1  packet in progress
- credits_o  out  CREDIT_W  current credit count
- err_o  out  1  sticky protocol/credit error

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE; rr_ptr=NUM_REQ-1, so index 0 has first priority; credits=BUFFER_DEPTH; out_valid_o=0; out_flit_o=0; grant_o=0; locked_o=0; err_o=0.
- Reset mid-packet: the packet is abandoned. There is no partial-TAIL emission.
- FSM states: IDLE and LOCKED.
- IDLE arbitration:
  - Eligible requester: req_valid_i[i]=1 and flit_label is HEAD or HEADTAIL.
  - Winner w: first eligible index found searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - If credits>0, req_ready_o[w]=1 in the same cycle (combinational); all other readies are 0.
- Winner's label in IDLE:
  - HEAD: go to LOCKED with owner=w.
  - HEADTAIL: stay in IDLE and set rr_ptr=w.
- Non-head flits in IDLE are never accepted (ready=0) and are not errors. They wait.
- LOCKED:
  - req_ready_o[owner]=(credits>0); all other readies are 0.
  - Every owner flit is forwarded unchanged.
  - TAIL or HEADTAIL closes the packet: go to IDLE and set rr_ptr=owner.
  - HEAD or HEADTAIL from the owner while LOCKED sets err_o. A HEAD does not close the packet.
- Forwarding latency is 1 cycle:
  - A transfer in cycle N gives out_valid_o=1 and out_flit_o=that flit in cycle N+1. Pass-through is bit-exact, including vc_id.
  - out_valid_o=0 in any cycle following no transfer; out_flit_o holds its last value.
  - At most one transfer per cycle, so sustained throughput is 1 flit/cycle while credits last.
- Credits:
  - Transfer only: credits-1.
  - credit_return_i only: credits+1.
  - Both in the same cycle: unchanged.
  - credits==0: no transfer, and state is held. Arbitration still computes a winner but does not commit it.
  - credit_return_i while credits==BUFFER_DEPTH and no transfer: counter saturates and err_o is set.
- grant_o and locked_o reflect registered state. grant_o is one-hot owner in LOCKED and zero in IDLE.
- rr_ptr updates only on packet completion (TAIL/HEADTAIL accepted).
- No combinational path from credit_return_i to any output. credit_return_i affects ready only from the next cycle.
- err_o clears only on rst.

Test Plan:
- Single-flit packet: after reset, HEADTAIL valid on input 2 only -> req_ready_o=5'b00100 the same cycle; next cycle out_valid_o=1 with an identical flit; credits_o 8->7; rr_ptr=2; state stays IDLE.
- Fairness: inputs 0, 1 and 4 continuously offer HEADTAIL flits, with a credit returned every cycle -> grants in order 0, 1, 4, 0, 1, 4; credits_o constant at 7 after the first transfer.
- Packet locking: input 3 sends HEAD, BODY, BODY, TAIL while input 0 offers HEAD throughout -> input 0 ready stays 0 until the cycle after the TAIL transfer; output shows the 4 input-3 flits contiguously, then input 0's HEAD.
- Credit exhaustion: 10-flit packet with no credit_return_i -> exactly 8 flits forwarded, credits_o=0, ready=0, locked_o=1; one credit_return_i pulse -> exactly one more flit, the cycle after the pulse.
- Simultaneous transfer and credit return at credits_o=5 -> credits_o stays 5. A return at credits_o=8 with no transfer -> credits_o=8 and err_o=1 sticky.
- Reset mid-packet: rst asserted after the HEAD and 1 BODY of a packet -> next cycle locked_o=0, grant_o=0, credits_o=8, out_valid_o=0; a new HEADTAIL on input 1 is then accepted normally.
